alu_cmd_issue: RTL and testbench

- Upstream issue stage for the 32-bit ALU. Accepts ALU commands (operands, control, tag) on a valid/ready port and buffers them in a FIFO.
- Drives one command per cycle onto the ALU operand/control inputs.
- Captures the combinational ALU result and Zero flag, then returns them with the command's tag on a valid/ready response port.
- Provides in-order, back-pressured, full-throughput command flow into the ALU.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_cmd_fifo.sv | 60 ++++++
 rtl/alu_cmd_issue.sv | 92 +++++++++
 tb/tb_alu_cmd_issue.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, ALU control encoding and command record for the ALU issue stage
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 3;
  localparam int TAG_W  = 4;

  // Known ALU encodings; the issue stage carries ctrl opaquely and never decodes it.
  typedef enum logic [CTRL_W-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [CTRL_W-1:0] ctrl;
    logic [TAG_W-1:0]  tag;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous FIFO of alu_cmd_t with registered full/empty/count
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  alu_cmd_t      push_data,
  input  logic          pop,
  output alu_cmd_t      pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  alu_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage is not reset: validity is tracked entirely by count and pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_issue.sv
// rtl/alu_cmd_issue.sv - in-order issue stage: command FIFO -> ALU operand register -> response register
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  input  logic [CTRL_W-1:0] cmd_ctrl_i,
  input  logic [TAG_W-1:0]  cmd_tag_i,
  output logic [DATA_W-1:0] dataA_o,
  output logic [DATA_W-1:0] dataB_o,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  input  logic [DATA_W-1:0] ALUResult_i,
  input  logic              Zero_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_zero_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  output logic [CW-1:0]     fifo_count_o
);

  alu_cmd_t push_cmd;
  alu_cmd_t head_cmd;
  alu_cmd_t issue_cmd;
  logic     issue_vld;
  logic     fifo_full;
  logic     fifo_empty;
  logic     rsp_can;
  logic     issue_adv;
  logic     do_pop;

  assign push_cmd    = {cmd_a_i, cmd_b_i, cmd_ctrl_i, cmd_tag_i};
  assign cmd_ready_o = !fifo_full;
  assign rsp_can     = !rsp_valid_o || rsp_ready_i;
  assign issue_adv   = !issue_vld || rsp_can;
  assign do_pop      = issue_adv && !fifo_empty;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (cmd_valid_i),
    .push_data (push_cmd),
    .pop       (do_pop),
    .pop_data  (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_o)
  );

  // Operands are left at their last value when nothing issues, keeping the ALU inputs quiet.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_cmd <= '0;
      issue_vld <= 1'b0;
    end else if (issue_adv) begin
      if (!fifo_empty) begin
        issue_cmd <= head_cmd;
        issue_vld <= 1'b1;
      end else begin
        issue_vld <= 1'b0;
      end
    end
  end

  assign dataA_o   = issue_cmd.a;
  assign dataB_o   = issue_cmd.b;
  assign ALUCtrl_o = issue_cmd.ctrl;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o  <= 1'b0;
      rsp_result_o <= '0;
      rsp_zero_o   <= 1'b0;
      rsp_tag_o    <= '0;
    end else if (issue_vld && rsp_can) begin
      rsp_valid_o  <= 1'b1;
      rsp_result_o <= ALUResult_i;
      rsp_zero_o   <= Zero_i;
      rsp_tag_o    <= issue_cmd.tag;
    end else if (rsp_ready_i) begin
      rsp_valid_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// tb/tb_alu_cmd_issue.sv - randomized scoreboard bench for alu_cmd_issue with a behavioural ALU
module tb_alu_cmd_issue;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [CTRL_W-1:0] cmd_ctrl;
  logic [TAG_W-1:0]  cmd_tag;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic [TAG_W-1:0]  rsp_tag;
  logic [CW-1:0]     fifo_count;

  always #5 clk = ~clk;

  alu_cmd_issue #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_a_i      (cmd_a),
    .cmd_b_i      (cmd_b),
    .cmd_ctrl_i   (cmd_ctrl),
    .cmd_tag_i    (cmd_tag),
    .dataA_o      (data_a),
    .dataB_o      (data_b),
    .ALUCtrl_o    (alu_ctrl),
    .ALUResult_i  (alu_result),
    .Zero_i       (alu_zero),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .rsp_zero_o   (rsp_zero),
    .rsp_tag_o    (rsp_tag),
    .fifo_count_o (fifo_count)
  );

  function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                              input logic [CTRL_W-1:0] c);
    case (c)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_f(data_a, data_b, alu_ctrl);
  assign alu_zero   = (alu_result == '0);

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              z;
    logic [TAG_W-1:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [CTRL_W-1:0] ops [5] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, obs, exp, $time);
    end
  endtask

  // Inspect at the falling edge, then advance through one rising edge and update the scoreboard.
  task automatic tick();
    logic acc, fire;
    exp_t e;
    @(negedge clk);
    acc = cmd_valid && cmd_ready;
    fire = rsp_valid && rsp_ready;
    e.res = alu_f(cmd_a, cmd_b, cmd_ctrl);
    e.z   = (e.res == '0);
    e.tag = cmd_tag;
    check("count_le_depth", 64'(fifo_count <= CW'(DEPTH)), 64'd1);
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("stale_rsp", 64'd1, 64'd0);
      end else begin
        check("rsp_result", 64'(rsp_result), 64'(sb[0].res));
        check("rsp_zero", 64'(rsp_zero), 64'(sb[0].z));
        check("rsp_tag", 64'(rsp_tag), 64'(sb[0].tag));
      end
    end
    @(posedge clk);
    #1;
    if (acc) sb.push_back(e);
    if (fire && sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic drive(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [CTRL_W-1:0] c, input logic [TAG_W-1:0] t);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_ctrl = c;
    cmd_tag = t;
  endtask

  task automatic drive_rand();
    logic [DATA_W-1:0] a;
    a = $urandom;
    drive(a, ($urandom_range(0, 3) == 0) ? a : 32'($urandom), ops[$urandom_range(0, 4)], 4'($urandom));
  endtask

  task automatic drain();
    int n;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    tick();
    check("drain_empty", 64'(sb.size()), 64'd0);
    check("drain_rsp_valid", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_ctrl = '0;
    cmd_tag = '0;
    rsp_ready = 1'b1;
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_data_a", 64'(data_a), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single op latency
    drive(32'd5, 32'd7, ALU_ADD, 4'd3);
    tick();
    cmd_valid = 1'b0;
    check("lat_e0_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    check("lat_e1_data_a", 64'(data_a), 64'd5);
    check("lat_e1_data_b", 64'(data_b), 64'd7);
    check("lat_e1_ctrl", 64'(alu_ctrl), 64'(ALU_ADD));
    check("lat_e1_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    check("lat_e2_rsp_valid", 64'(rsp_valid), 64'd1);
    check("lat_e2_result", 64'(rsp_result), 64'd12);
    check("lat_e2_zero", 64'(rsp_zero), 64'd0);
    check("lat_e2_tag", 64'(rsp_tag), 64'd3);
    drain();

    // Back-to-back at full throughput
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin
        drive_rand();
        cmd_tag = 4'(i);
        check("b2b_cmd_ready", 64'(cmd_ready), 64'd1);
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      check("b2b_rsp_valid", 64'(rsp_valid), 64'(i >= 2 && i <= 9));
      if (i >= 2 && i <= 9) check("b2b_tag_order", 64'(rsp_tag), 64'(i - 2));
    end
    drain();

    // Backpressure fills the FIFO
    rsp_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_rand();
      cmd_tag = 4'(i);
      tick();
    end
    cmd_valid = 1'b0;
    check("bp_count_full", 64'(fifo_count), 64'(DEPTH));
    check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    check("bp_accepted", 64'(sb.size()), 64'd6);
    tick();
    check("bp_hold_count", 64'(fifo_count), 64'(DEPTH));
    drain();

    // Zero flag including wrap-around
    drive(32'd9, 32'd9, ALU_SUB, 4'd1);
    tick();
    drive(32'hFFFF_FFFF, 32'd1, ALU_ADD, 4'd2);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("zero_sub_result", 64'(rsp_result), 64'd0);
    check("zero_sub_flag", 64'(rsp_zero), 64'd1);
    tick();
    check("zero_wrap_result", 64'(rsp_result), 64'd0);
    check("zero_wrap_flag", 64'(rsp_zero), 64'd1);
    check("zero_wrap_tag", 64'(rsp_tag), 64'd2);
    drain();

    // Reset with commands in flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      tick();
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mrst_rsp_result", 64'(rsp_result), 64'd0);
    check("mrst_data_a", 64'(data_a), 64'd0);
    check("mrst_count", 64'(fifo_count), 64'd0);
    check("mrst_cmd_ready", 64'(cmd_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    drive(32'd20, 32'd6, ALU_SUB, 4'd9);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("mrst_e1_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    check("mrst_e2_rsp_valid", 64'(rsp_valid), 64'd1);
    check("mrst_e2_result", 64'(rsp_result), 64'd14);
    drain();

    // Steady push/pop at DEPTH-1 across pointer wrap
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_rand();
      tick();
    end
    check("wrap_fill_count", 64'(fifo_count), 64'(DEPTH - 1));
    rsp_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      drive_rand();
      tick();
      check("wrap_count_stable", 64'(fifo_count), 64'(DEPTH - 1));
    end
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) drive_rand();
      else cmd_valid = 1'b0;
      rsp_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
